vga_fifo_reader: RTL and testbench
==================================

Name: vga_fifo_reader

Overview:
- Consumer end of the frame FIFO that the display address generator fills: one 25-bit word per 8 horizontal pixels, 80 words per line, 480 lines per frame.
- Generates 640x480@60 VGA timing on a pixel-clock enable.
- Pops one FIFO word per 8-pixel group during active video and holds its RGB for 8 pixels.
- Drives hsync/vsync/de/RGB to the DAC pins and flags FIFO underflow.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
PIX_REP, 8, pixels per FIFO word; power of two

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
pix_en  in  1  pixel tick, one clk wide; asserted at most every 2nd clk
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  25  FIFO read data; [23:16]=R, [15:8]=G, [7:0]=B, bit 24 ignored
fifo_ren  out  1  FIFO read strobe, one clk per pop
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
de  out  1  data enable (active video)
red  out  8  pixel red
green  out  8  pixel green
blue  out  8  pixel blue
frame_start  out  1  one-clk pulse when pixel (0,0) is presented
underflow  out  1  sticky flag: a fetch found the FIFO empty

Behaviour:
- Reset values: fifo_ren=0, hsync=1, vsync=1, de=0, red/green/blue=0, frame_start=0, underflow=0. h_cnt, v_cnt, hold register and state are cleared.
- Reset mid-frame: outputs take reset values on the next clk, and the block re-enters IDLE.
- State IDLE:
  - Counters held at 0; syncs inactive (high); outputs blank.
  - On the first pix_en tick with !fifo_empty, go to RUN. That tick is treated as h=0, v=0.
- State RUN:
  - h_cnt runs 0..799 on each pix_en tick.
  - v_cnt increments when h_cnt wraps 799->0 and runs 0..524, wrapping to 0.
  - Counters do not change on clks without pix_en.
  - RUN never returns to IDLE except via rst.
- Fetch rule:
  - On a pix_en tick in RUN with h_cnt<640, v_cnt<480 and h_cnt[2:0]==0:
    - If !fifo_empty: fifo_ren=1 for that clk only.
    - If fifo_empty: no ren; underflow<=1; the group is marked blank.
  - FIFO read latency is 1 clk. The hold register captures fifo_dout[23:0] on the clk after fifo_ren.
  - Exactly 80 pops per active line and 38400 per frame. No pops during blanking.
- Output pipeline:
  - All outputs are registered and updated only on pix_en ticks.
  - Outputs reflect the counter state of the previous tick (uniform 1-pixel latency).
  - de=1 iff the previous (h,v) was active.
  - hsync=0 iff the previous h is in 656..751.
  - vsync=0 iff the previous v is in 490..491.
  - RGB = hold register when de=1 and the group is not blank; otherwise 0.
  - The word fetched at tick t drives pixels presented at ticks t+1..t+8. A new fetch at t+8 updates hold only after tick t+8 has registered pixel h+7.
- frame_start:
  - High for exactly the one clk on which pixel (0,0) is registered to the outputs (de rising at the first active pixel of a frame).
  - Low otherwise, including in IDLE.
- Underflow:
  - Sticky until rst.
  - The affected 8-pixel group is output black with de=1.
  - Timing continues; the next group fetches normally.
- Simultaneous fifo_empty deassert and fetch tick: the sampled value of fifo_empty on that clk decides.
- Width rules:
  - h_cnt is 10 bits, v_cnt is 10 bits.
  - Compare limits are derived from parameters (H_TOTAL = sum of horizontal params, V_TOTAL = sum of vertical params).

Test Plan:
- Reset then FIFO held non-empty with word k = {1'b0, k[23:0]}, pix_en every 4 clks, run 2 frames -> 38400 ren pulses per frame; pixel (8j+i, y) has RGB = word 80y+j; de=0 in blanking; underflow stays 0.
- Sync timing, same run -> hsync low for 96 ticks starting 1 tick after h=656; line period 800 ticks; vsync low for 2 lines (1600 ticks) starting at line 490; frame period 420000 ticks.
- fifo_empty=1 after reset for 1000 clks, then 0 -> no ren, hsync=vsync=1, de=0 throughout the wait; first ren occurs on the first pix_en tick after fifo_empty falls; frame_start pulses 1 tick later.
- Force fifo_empty=1 on the fetch tick for h=80, v=10 -> no ren on that tick; pixels 80..87 of line 10 are RGB=0 with de=1; underflow=1 and remains 1; pixels 88..95 show the next word.
- Assert rst for 1 clk at h=300, v=200 with pix_en every 2 clks -> next clk: de=0, hsync=vsync=1, RGB=0, fifo_ren=0; block waits in IDLE and restarts at (0,0) once the FIFO is non-empty.
- pix_en continuously low for 50 clks mid-line -> counters, outputs and fifo_ren frozen; no extra pops.

Source files
------------

// File: rtl/vga_fifo_reader.sv
// VGA timing generator that drains the display frame FIFO: one word per PIX_REP-pixel
// group during active video, with every output delayed by exactly one pixel tick.
module vga_fifo_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_REP  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        fifo_empty,
  input  logic [24:0] fifo_dout,
  output logic        fifo_ren,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GRP_MASK = 10'(PIX_REP - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [9:0]  hCnt_q, hCnt_d, vCnt_q, vCnt_d;
  logic        tick, fetch;
  logic        curActive, curHsync, curVsync, curFirst;
  logic        prevActive_q, prevHsync_q, prevVsync_q, prevFirst_q;
  logic        renDly_q, blank_q;
  logic [23:0] hold_q, rgb_q;
  logic        de_q, hsync_q, vsync_q, frameStart_q, underflow_q;
  logic        unusedDout;

  assign unusedDout = fifo_dout[24];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && pix_en && !fifo_empty) state_d = RUN;
  end

  // The tick that leaves IDLE is already pixel (0,0), so it advances counters and fetches.
  always_comb begin
    tick     = pix_en && (state_q == RUN || !fifo_empty);
    fetch    = tick && curActive && ((hCnt_q & GRP_MASK) == 10'd0);
    fifo_ren = fetch && !fifo_empty && !rst;
  end

  always_comb begin
    curActive = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
    curHsync  = !((hCnt_q >= HS_BEG) && (hCnt_q < HS_END));
    curVsync  = !((vCnt_q >= VS_BEG) && (vCnt_q < VS_END));
    curFirst  = (hCnt_q == 10'd0) && (vCnt_q == 10'd0);
  end

  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (tick) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = 10'd0;
        vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
      end else begin
        hCnt_d = hCnt_q + 10'd1;
      end
    end
  end

  // blank_q switches on the fetch tick while hold_q lands a clk later; both are read
  // only on the following tick, so the previous group's last pixel is never disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      hCnt_q       <= 10'd0;
      vCnt_q       <= 10'd0;
      prevActive_q <= 1'b0;
      prevHsync_q  <= 1'b1;
      prevVsync_q  <= 1'b1;
      prevFirst_q  <= 1'b0;
      renDly_q     <= 1'b0;
      blank_q      <= 1'b0;
      hold_q       <= 24'd0;
      rgb_q        <= 24'd0;
      de_q         <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frameStart_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      renDly_q     <= fifo_ren;
      frameStart_q <= 1'b0;
      if (renDly_q) hold_q <= fifo_dout[23:0];
      if (tick) begin
        prevActive_q <= curActive;
        prevHsync_q  <= curHsync;
        prevVsync_q  <= curVsync;
        prevFirst_q  <= curFirst;
        de_q         <= prevActive_q;
        hsync_q      <= prevHsync_q;
        vsync_q      <= prevVsync_q;
        rgb_q        <= (prevActive_q && !blank_q) ? hold_q : 24'd0;
        frameStart_q <= prevFirst_q;
        if (fetch) begin
          blank_q <= fifo_empty;
          if (fifo_empty) underflow_q <= 1'b1;
        end
      end
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign frame_start = frameStart_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Directed bench for vga_fifo_reader on a shrunken raster (120x19 total, 80x12 active)
// so that whole frames, sync pulses, an underflow and a mid-frame reset fit in one short run.
module tb_vga_fifo_reader;

  localparam int HA = 80, HF = 8, HS = 16, HB = 16, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int WPL = HA / 8;
  localparam int WPF = WPL * VA;
  localparam int FT  = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [24:0] fifo_dout = 25'd0;
  logic        fifo_ren, hsync, vsync, de, frame_start, underflow;
  logic [7:0]  red, green, blue;

  int  errors = 0, checks = 0;
  int  pixDiv = 4, phase = 0;
  bit  freeze = 0, emptyReq = 1, rstReq = 1;
  bit  started = 0, lastRen = 0, rstSeen = 0;
  int  tickIdx = 0, wordBase = 0, popIdx = 0;
  int  ufTick = -1, rstTick = -1;
  int  pixErr = 0, renErr = 0, fsErr = 0, idleErr = 0;
  int  renCnt = 0, hsLow = 0, vsLow = 0, deCnt = 0;

  vga_fifo_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_REP(8)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_ren(fifo_ren), .hsync(hsync), .vsync(vsync),
    .de(de), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference raster: output at tick n shows position n-1 of the epoch that began
  // with the start pop; one forced-empty group shifts later words down by one.
  task automatic checkOutput(input bit renNow);
    int p, r, f, h, v, wIdx;
    bit expDe, expHs, expVs, expRen, expFs, black;
    logic [23:0] expRgb;
    if (rst) begin
      started = 0;
      ufTick  = -1;
      rstTick = -1;
      return;
    end
    if (!started) begin
      if (renNow) begin
        started  = 1;
        tickIdx  = 0;
        wordBase = popIdx;
      end else if (de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || frame_start !== 1'b0) begin
        idleErr++;
      end
      return;
    end
    if (!pix_en) begin
      if (renNow !== 1'b0) renErr++;
      if (frame_start !== 1'b0) fsErr++;
      return;
    end
    tickIdx++;
    r = tickIdx % FT; v = r / HT; h = r % HT;
    expRen = (h < HA) && (v < VA) && (h % 8 == 0) && !fifo_empty;
    if (renNow !== expRen) renErr++;
    if (renNow) renCnt++;
    p = tickIdx - 1; f = p / FT; r = p % FT; v = r / HT; h = r % HT;
    expDe = (h < HA) && (v < VA);
    expHs = !((h >= HA + HF) && (h < HA + HF + HS));
    expVs = !((v >= VA + VF) && (v < VA + VF + VS));
    expFs = (h == 0) && (v == 0);
    black = (ufTick >= 0) && (p >= ufTick) && (p < ufTick + 8);
    wIdx  = wordBase + f * WPF + v * WPL + h / 8 - (((ufTick >= 0) && (p >= ufTick + 8)) ? 1 : 0);
    expRgb = (expDe && !black) ? 24'(wIdx) : 24'd0;
    if (de !== expDe || hsync !== expHs || vsync !== expVs || {red, green, blue} !== expRgb)
      pixErr++;
    if (frame_start !== expFs) fsErr++;
    if (!hsync) hsLow++;
    if (!vsync) vsLow++;
    if (de) deCnt++;
  endtask

  // One clk: drive inputs at negedge, sample the combinational strobe, then the
  // registered outputs #1 after posedge; the FIFO returns popped data a clk later.
  task automatic applyStimulus();
    bit renNow;
    @(negedge clk);
    pix_en     = !freeze && (phase == 0);
    phase      = (phase + 1) % pixDiv;
    fifo_empty = emptyReq || (started && pix_en && (tickIdx + 1 == ufTick));
    rst        = rstReq || (started && pix_en && (tickIdx + 1 == rstTick));
    if (rst) rstSeen = 1;
    #1;
    renNow  = fifo_ren;
    lastRen = renNow;
    @(posedge clk);
    #1;
    checkOutput(renNow);
    if (renNow) begin
      fifo_dout = {1'b0, 24'(popIdx)};
      popIdx++;
    end
  endtask

  task automatic runUntil(input int target);
    int budget, n;
    budget = (target + 8) * pixDiv + 64;
    n = 0;
    while (!(started && tickIdx >= target) && n < budget) begin
      applyStimulus();
      n++;
    end
    check("reach_tick", 32'(started && tickIdx >= target), 32'd1);
  endtask

  initial begin
    logic [28:0] snap;
    int popSnap, n, pixSeen, frzErr;

    $display("[TB] reset and idle");
    repeat (4) applyStimulus();
    rstReq = 0;
    applyStimulus();
    check("rst_de", de, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_underflow", underflow, 0);
    check("rst_ren", lastRen, 0);

    repeat (1000) applyStimulus();
    check("idle_outputs", idleErr, 0);
    check("idle_pops", popIdx, 0);

    emptyReq = 0;
    pixSeen = 0; n = 0;
    while (!started && n < 16) begin
      applyStimulus();
      if (pix_en) pixSeen++;
      n++;
    end
    check("start_seen", started, 1);
    check("start_first_tick", pixSeen, 1);
    check("start_tick_fs", frame_start, 0);
    check("start_tick_de", de, 0);
    runUntil(1);
    check("first_pix_fs", frame_start, 1);
    check("first_pix_de", de, 1);
    applyStimulus();
    check("fs_one_clk", frame_start, 0);

    $display("[TB] two full frames");
    runUntil(9);    check("pix_8_0_rgb", {red, green, blue}, 1);
    runUntil(80);   check("pix_79_0_rgb", {red, green, blue}, 9);
                    check("pix_79_0_de", de, 1);
    runUntil(81);   check("pix_80_0_de", de, 0);
                    check("pix_80_0_rgb", {red, green, blue}, 0);
    runUntil(88);   check("hs_before", hsync, 1);
    runUntil(89);   check("hs_first", hsync, 0);
    runUntil(104);  check("hs_last", hsync, 0);
    runUntil(105);  check("hs_after", hsync, 1);
    runUntil(121);  check("pix_0_1_rgb", {red, green, blue}, 10);
    runUntil(1680); check("vs_before", vsync, 1);
    runUntil(1681); check("vs_first", vsync, 0);
    runUntil(1920); check("vs_last", vsync, 0);
    runUntil(1921); check("vs_after", vsync, 1);
    runUntil(2 * FT);
    check("frames_pixels", pixErr, 0);
    check("frames_ren", renErr, 0);
    check("frames_fs", fsErr, 0);
    check("frames_pop_count", renCnt, 240);
    check("frames_hs_low", hsLow, 608);
    check("frames_vs_low", vsLow, 480);
    check("frames_de_count", deCnt, 1920);
    check("frames_underflow", underflow, 0);

    $display("[TB] underflow at (40,10)");
    ufTick = 2 * FT + 10 * HT + 40;
    runUntil(ufTick);
    check("uf_no_ren", lastRen, 0);
    check("uf_flag", underflow, 1);
    check("uf_prev_group", {red, green, blue}, 344);
    runUntil(ufTick + 1); check("uf_black_de", de, 1);
                          check("uf_black_rgb", {red, green, blue}, 0);
    runUntil(ufTick + 8); check("uf_black_end", {red, green, blue}, 0);
    runUntil(ufTick + 9); check("uf_next_word", {red, green, blue}, 345);
                          check("uf_sticky", underflow, 1);

    $display("[TB] pix_en frozen mid-line");
    runUntil(ufTick + 20);
    snap = {hsync, vsync, de, red, green, blue, frame_start, underflow};
    popSnap = popIdx;
    frzErr = 0;
    freeze = 1;
    repeat (50) begin
      applyStimulus();
      if ({hsync, vsync, de, red, green, blue, frame_start, underflow} !== snap || lastRen !== 1'b0)
        frzErr++;
    end
    freeze = 0;
    check("freeze_outputs", frzErr, 0);
    check("freeze_pops", popIdx, popSnap);
    runUntil(3 * FT);
    check("frame2_pixels", pixErr, 0);
    check("frame2_ren", renErr, 0);
    check("frame2_fs", fsErr, 0);
    check("frame2_underflow", underflow, 1);

    $display("[TB] reset at (30,5)");
    pixDiv = 2;
    rstTick = 3 * FT + 5 * HT + 30;
    runUntil(rstTick - 1);
    check("pre_rst_de", de, 1);
    rstSeen = 0; n = 0;
    while (!rstSeen && n < 16) begin
      applyStimulus();
      n++;
    end
    check("rst_applied", rstSeen, 1);
    check("midrst_de", de, 0);
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    check("midrst_rgb", {red, green, blue}, 0);
    check("midrst_underflow", underflow, 0);
    emptyReq = 1;
    applyStimulus();
    check("midrst_ren", lastRen, 0);
    repeat (20) applyStimulus();
    check("midrst_idle", idleErr, 0);
    emptyReq = 0;
    n = 0;
    while (!started && n < 16) begin
      applyStimulus();
      n++;
    end
    check("restart_seen", started, 1);
    runUntil(1);
    check("restart_fs", frame_start, 1);
    check("restart_de", de, 1);
    check("restart_rgb", {red, green, blue}, 413);
    runUntil(HT + 2);
    check("restart_pixels", pixErr, 0);
    check("restart_ren", renErr, 0);
    check("restart_fs_all", fsErr, 0);
    check("restart_underflow", underflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
